// File: rtl/lcd_pkg.sv
// Shared types and constants for the ILI9341 pixel writer: FSM states, panel
// opcodes and the byte table that homes the cursor to the full window.
package lcd_pkg;

  typedef enum logic [2:0] {
    RST_LOW,
    RST_WAIT,
    INIT_A,
    SLEEP_WAIT,
    INIT_B,
    CURSOR,
    IDLE,
    PIX
  } lcd_state_e;

  localparam logic [7:0] SLPOUT = 8'h11;
  localparam logic [7:0] COLMOD = 8'h3A;
  localparam logic [7:0] MADCTL = 8'h36;
  localparam logic [7:0] DISPON = 8'h29;
  localparam logic [7:0] CASET  = 8'h2A;
  localparam logic [7:0] PASET  = 8'h2B;
  localparam logic [7:0] RAMWR  = 8'h2C;

  localparam logic [7:0] COLMOD_RGB565 = 8'h55;

  localparam int LCD_W = 320;
  localparam int LCD_H = 240;

  localparam logic [15:0] X_END = 16'(LCD_W - 1);
  localparam logic [15:0] Y_END = 16'(LCD_H - 1);

  localparam int CURSOR_LEN = 11;

  // Entries are {cmd_data, byte}: bit 8 set means a data byte.
  localparam logic [8:0] CURSOR_TBL [0:CURSOR_LEN-1] = '{
    {1'b0, CASET},
    {1'b1, 8'h00}, {1'b1, 8'h00}, {1'b1, X_END[15:8]}, {1'b1, X_END[7:0]},
    {1'b0, PASET},
    {1'b1, 8'h00}, {1'b1, 8'h00}, {1'b1, Y_END[15:8]}, {1'b1, Y_END[7:0]},
    {1'b0, RAMWR}
  };

endpackage

// File: rtl/lcd_pixel_writer_byte_tx.sv
// Single-byte 8080 write strobe: WRX low for WR_HALF cycles, then high for
// WR_HALF cycles, with dout/cmd_data held for the whole window.
module lcd_byte_tx #(
  parameter int WR_HALF = 1
) (
  input  logic       clk_i,
  input  logic       resetn,
  input  logic       start,
  input  logic       is_data,
  input  logic [7:0] byte_val,
  output logic       done,
  output logic       write_edge,
  output logic [7:0] dout,
  output logic       cmd_data
);

  localparam int PH_W = (WR_HALF > 1) ? $clog2(WR_HALF) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(WR_HALF - 1);

  logic            active_r;
  logic [PH_W-1:0] ph_cnt_r;
  logic            write_edge_r;
  logic [7:0]      dout_r;
  logic            cmd_data_r;

  // done marks the last high cycle so the next start lands with no gap.
  assign done       = active_r && write_edge_r && (ph_cnt_r == PH_LAST);
  assign write_edge = write_edge_r;
  assign dout       = dout_r;
  assign cmd_data   = cmd_data_r;

  // Byte launch and low/high phase sequencing.
  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) begin
      active_r     <= 1'b0;
      ph_cnt_r     <= '0;
      write_edge_r <= 1'b1;
      dout_r       <= 8'h00;
      cmd_data_r   <= 1'b0;
    end else if (start) begin
      active_r     <= 1'b1;
      ph_cnt_r     <= '0;
      write_edge_r <= 1'b0;
      dout_r       <= byte_val;
      cmd_data_r   <= is_data;
    end else if (active_r) begin
      if (ph_cnt_r == PH_LAST) begin
        ph_cnt_r <= '0;
        if (!write_edge_r) begin
          write_edge_r <= 1'b1;
        end else begin
          active_r <= 1'b0;
        end
      end else begin
        ph_cnt_r <= ph_cnt_r + PH_W'(1);
      end
    end
  end

endmodule

// File: rtl/lcd_pixel_writer.sv
// ILI9341 8080-bus writer: panel reset and init, cursor homing, and RGB565
// pixel serialisation of the TIA beam-raced stream, with busy back-pressure.
module lcd_pixel_writer
  import lcd_pkg::*;
#(
  parameter int         RESET_LOW_CYC  = 16000,
  parameter int         RESET_WAIT_CYC = 1920000,
  parameter int         SLEEP_WAIT_CYC = 80000,
  parameter int         WR_HALF        = 1,
  parameter logic [7:0] MADCTL_VAL     = 8'h28
) (
  input  logic        clk_i,
  input  logic        resetn,
  input  logic [15:0] pix_data,
  input  logic        pix_clk,
  input  logic        reset_cursor,
  output logic        busy,
  output logic        nreset,
  output logic        cmd_data,
  output logic        write_edge,
  output logic [7:0]  dout
);

  localparam int MAX_A    = (RESET_LOW_CYC > RESET_WAIT_CYC) ? RESET_LOW_CYC : RESET_WAIT_CYC;
  localparam int MAX_WAIT = (MAX_A > SLEEP_WAIT_CYC) ? MAX_A : SLEEP_WAIT_CYC;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);

  lcd_state_e       state_r;
  logic [3:0]       idx_r;
  logic [CNT_W-1:0] cnt_r;
  logic [15:0]      pix_r;
  logic             nreset_r;
  logic             busy_r;

  logic [CNT_W-1:0] wait_lim_s;
  logic             wait_done_s;
  logic [3:0]       last_idx_s;
  logic             emitting_s;
  logic             seq_end_s;
  logic             launch_s;
  lcd_state_e       launch_state_s;
  logic [3:0]       launch_idx_s;
  logic [15:0]      pix_sel_s;
  logic [8:0]       tx_word_s;
  logic             tx_done_s;

  function automatic logic [8:0] seq_byte(input lcd_state_e st, input logic [3:0] idx,
                                          input logic [15:0] px);
    logic [8:0] w;
    w = 9'h000;
    case (st)
      INIT_A: w = {1'b0, SLPOUT};
      INIT_B: begin
        case (idx)
          4'd0:    w = {1'b0, COLMOD};
          4'd1:    w = {1'b1, COLMOD_RGB565};
          4'd2:    w = {1'b0, MADCTL};
          4'd3:    w = {1'b1, MADCTL_VAL};
          default: w = {1'b0, DISPON};
        endcase
      end
      CURSOR:  w = (idx < 4'(CURSOR_LEN)) ? CURSOR_TBL[idx] : 9'h000;
      PIX:     w = (idx == 4'd0) ? {1'b1, px[15:8]} : {1'b1, px[7:0]};
      default: w = 9'h000;
    endcase
    return w;
  endfunction

  // Wait limits and end-of-sequence detection for the current state.
  always_comb begin
    wait_lim_s = '0;
    last_idx_s = 4'd0;
    emitting_s = 1'b0;
    case (state_r)
      RST_LOW:    wait_lim_s = CNT_W'(RESET_LOW_CYC - 1);
      RST_WAIT:   wait_lim_s = CNT_W'(RESET_WAIT_CYC - 1);
      SLEEP_WAIT: wait_lim_s = CNT_W'(SLEEP_WAIT_CYC - 1);
      INIT_A:     emitting_s = 1'b1;
      INIT_B: begin
        emitting_s = 1'b1;
        last_idx_s = 4'd4;
      end
      CURSOR: begin
        emitting_s = 1'b1;
        last_idx_s = 4'(CURSOR_LEN - 1);
      end
      PIX: begin
        emitting_s = 1'b1;
        last_idx_s = 4'd1;
      end
      default: wait_lim_s = '0;
    endcase
    wait_done_s = (cnt_r == wait_lim_s);
    seq_end_s   = emitting_s && tx_done_s && (idx_r == last_idx_s);
  end

  // Byte launch decision; the first byte of a sequence starts on the same edge
  // as the state change so a strobe at edge N drops write_edge at N+1.
  always_comb begin
    launch_s       = 1'b0;
    launch_state_s = state_r;
    launch_idx_s   = 4'd0;
    case (state_r)
      RST_WAIT, SLEEP_WAIT: begin
        if (wait_done_s) begin
          launch_s       = 1'b1;
          launch_state_s = (state_r == RST_WAIT) ? INIT_A : INIT_B;
        end else begin
          launch_s = 1'b0;
        end
      end
      INIT_B: begin
        if (tx_done_s && seq_end_s) begin
          launch_s       = 1'b1;
          launch_state_s = CURSOR;
        end else if (tx_done_s) begin
          launch_s     = 1'b1;
          launch_idx_s = idx_r + 4'd1;
        end else begin
          launch_s = 1'b0;
        end
      end
      CURSOR, PIX: begin
        if (tx_done_s && !seq_end_s) begin
          launch_s     = 1'b1;
          launch_idx_s = idx_r + 4'd1;
        end else begin
          launch_s = 1'b0;
        end
      end
      IDLE: begin
        if (reset_cursor) begin
          launch_s       = 1'b1;
          launch_state_s = CURSOR;
        end else if (pix_clk) begin
          launch_s       = 1'b1;
          launch_state_s = PIX;
        end else begin
          launch_s = 1'b0;
        end
      end
      default: launch_s = 1'b0;
    endcase
    pix_sel_s = (state_r == IDLE) ? pix_data : pix_r;
    tx_word_s = seq_byte(launch_state_s, launch_idx_s, pix_sel_s);
  end

  // Sequencer FSM with registered nreset/busy.
  always_ff @(posedge clk_i or negedge resetn) begin
    if (!resetn) begin
      state_r  <= RST_LOW;
      idx_r    <= 4'd0;
      cnt_r    <= '0;
      pix_r    <= 16'h0000;
      nreset_r <= 1'b0;
      busy_r   <= 1'b1;
    end else if (launch_s) begin
      state_r <= launch_state_s;
      idx_r   <= launch_idx_s;
      cnt_r   <= '0;
      busy_r  <= 1'b1;
      if (state_r == IDLE) begin
        pix_r <= pix_data;
      end
    end else if (seq_end_s) begin
      idx_r <= 4'd0;
      if (state_r == INIT_A) begin
        state_r <= SLEEP_WAIT;
      end else begin
        state_r <= IDLE;
        busy_r  <= 1'b0;
      end
    end else if ((state_r == RST_LOW) && wait_done_s) begin
      state_r  <= RST_WAIT;
      nreset_r <= 1'b1;
      cnt_r    <= '0;
    end else if (state_r inside {RST_LOW, RST_WAIT, SLEEP_WAIT}) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  lcd_byte_tx #(
    .WR_HALF(WR_HALF)
  ) u_tx (
    .clk_i      (clk_i),
    .resetn     (resetn),
    .start      (launch_s),
    .is_data    (tx_word_s[8]),
    .byte_val   (tx_word_s[7:0]),
    .done       (tx_done_s),
    .write_edge (write_edge),
    .dout       (dout),
    .cmd_data   (cmd_data)
  );

  assign busy   = busy_r;
  assign nreset = nreset_r;

endmodule

// File: tb/tb_lcd_pixel_writer.sv
// Directed bench for lcd_pixel_writer with shortened reset/sleep waits; panel
// bytes are captured as {cmd_data, dout} on each rising write_edge.
module tb_lcd_pixel_writer;

  logic        clk;
  logic        resetn;
  logic [15:0] pix_data;
  logic        pix_clk;
  logic        reset_cursor;
  logic        busy;
  logic        nreset;
  logic        cmd_data;
  logic        write_edge;
  logic [7:0]  dout;

  int checks   = 0;
  int failures = 0;

  logic [8:0] cap_q [$];

  localparam logic [8:0] EXP_INIT [0:16] = '{
    9'h011, 9'h03A, 9'h155, 9'h036, 9'h128, 9'h029,
    9'h02A, 9'h100, 9'h100, 9'h101, 9'h13F,
    9'h02B, 9'h100, 9'h100, 9'h100, 9'h1EF, 9'h02C
  };

  lcd_pixel_writer #(
    .RESET_LOW_CYC (4),
    .RESET_WAIT_CYC(8),
    .SLEEP_WAIT_CYC(6),
    .WR_HALF       (1),
    .MADCTL_VAL    (8'h28)
  ) dut (
    .clk_i       (clk),
    .resetn      (resetn),
    .pix_data    (pix_data),
    .pix_clk     (pix_clk),
    .reset_cursor(reset_cursor),
    .busy        (busy),
    .nreset      (nreset),
    .cmd_data    (cmd_data),
    .write_edge  (write_edge),
    .dout        (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge write_edge) begin
    if (resetn === 1'b1) cap_q.push_back({cmd_data, dout});
  end

  task automatic wait_not_busy(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic exp_nr, exp_we;
    repeat (3) @(negedge clk);
    checks++;
    if ({nreset, cmd_data, write_edge, dout, busy} !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL reset_values: got nreset=%b cd=%b we=%b dout=%h busy=%b, want 0 0 1 00 1",
               nreset, cmd_data, write_edge, dout, busy);
    end
    resetn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      exp_nr = (k >= 4);
      exp_we = (k != 12);
      checks++;
      if ({nreset, write_edge, busy} !== {exp_nr, exp_we, 1'b1}) begin
        failures++;
        $display("FAIL powerup_cyc%0d: got nreset=%b we=%b busy=%b, want %b %b 1",
                 k, nreset, write_edge, busy, exp_nr, exp_we);
      end
    end
    checks++;
    if ({cmd_data, dout} !== {1'b0, 8'h11}) begin
      failures++;
      $display("FAIL first_cmd: got cd=%b dout=%h, want 0 11", cmd_data, dout);
    end
  endtask

  task automatic test_init_sequence();
    bit ok;
    wait_not_busy(200, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL init_timeout: busy still 1, want 0");
    end
    checks++;
    if (cap_q.size() !== 17) begin
      failures++;
      $display("FAIL init_count: got %0d bytes, want 17", cap_q.size());
    end
    for (int i = 0; i < 17 && i < cap_q.size(); i++) begin
      checks++;
      if (cap_q[i] !== EXP_INIT[i]) begin
        failures++;
        $display("FAIL init_byte%0d: got %h, want %h", i, cap_q[i], EXP_INIT[i]);
      end
    end
  endtask

  task automatic test_pixel();
    int base;
    base = cap_q.size();
    @(negedge clk);
    pix_data = 16'hF81F;
    pix_clk  = 1'b1;
    @(negedge clk);
    pix_clk  = 1'b0;
    checks++;
    if ({busy, write_edge, cmd_data, dout} !== {1'b1, 1'b0, 1'b1, 8'hF8}) begin
      failures++;
      $display("FAIL pix_first: got busy=%b we=%b cd=%b dout=%h, want 1 0 1 f8",
               busy, write_edge, cmd_data, dout);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'(k < 4)) begin
        failures++;
        $display("FAIL pix_busy_cyc%0d: got %b, want %b", k, busy, 1'(k < 4));
      end
      if (k == 2) begin
        checks++;
        if ({write_edge, dout} !== {1'b0, 8'h1F}) begin
          failures++;
          $display("FAIL pix_second: got we=%b dout=%h, want 0 1f", write_edge, dout);
        end
      end
    end
    checks++;
    if ((cap_q.size() - base) !== 2 || cap_q[base] !== 9'h1F8 || cap_q[base+1] !== 9'h11F) begin
      failures++;
      $display("FAIL pix_bytes: got %0d new bytes, want 1f8 11f", cap_q.size() - base);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [3];
    logic [8:0]  exp_b;
    int base, n_sent, cyc;
    vals[0] = 16'h0102;
    vals[1] = 16'hA5C3;
    vals[2] = 16'hFFFF;
    base   = cap_q.size();
    n_sent = 0;
    cyc    = 0;
    @(negedge clk);
    while ((n_sent < 3 || busy === 1'b1) && cyc < 100) begin
      if (busy === 1'b0 && n_sent < 3) begin
        pix_data = vals[n_sent];
        pix_clk  = 1'b1;
        n_sent++;
      end else begin
        pix_clk = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    pix_clk = 1'b0;
    checks++;
    if (cyc !== 15) begin
      failures++;
      $display("FAIL b2b_cycles: got %0d, want 15", cyc);
    end
    checks++;
    if ((cap_q.size() - base) !== 6) begin
      failures++;
      $display("FAIL b2b_count: got %0d bytes, want 6", cap_q.size() - base);
    end
    for (int i = 0; i < 6 && (base + i) < cap_q.size(); i++) begin
      exp_b = (i % 2 == 0) ? {1'b1, vals[i/2][15:8]} : {1'b1, vals[i/2][7:0]};
      checks++;
      if (cap_q[base+i] !== exp_b) begin
        failures++;
        $display("FAIL b2b_byte%0d: got %h, want %h", i, cap_q[base+i], exp_b);
      end
    end
  endtask

  task automatic test_ignore_while_busy();
    bit ok;
    int base;
    base = cap_q.size();
    @(negedge clk);
    pix_data = 16'hABCD;
    pix_clk  = 1'b1;
    @(negedge clk);
    pix_data = 16'h5555;
    @(negedge clk);
    pix_clk = 1'b0;
    wait_not_busy(50, ok);
    checks++;
    if (!ok || (cap_q.size() - base) !== 2 || cap_q[base] !== 9'h1AB || cap_q[base+1] !== 9'h1CD) begin
      failures++;
      $display("FAIL ign_pix: got ok=%b %0d bytes, want 1ab 1cd only", ok, cap_q.size() - base);
    end
    base = cap_q.size();
    @(negedge clk);
    reset_cursor = 1'b1;
    @(negedge clk);
    reset_cursor = 1'b0;
    pix_clk      = 1'b1;
    repeat (3) @(negedge clk);
    pix_clk = 1'b0;
    wait_not_busy(100, ok);
    checks++;
    if (!ok || (cap_q.size() - base) !== 11) begin
      failures++;
      $display("FAIL ign_cursor_count: got ok=%b %0d bytes, want 11", ok, cap_q.size() - base);
    end
    for (int i = 0; i < 11 && (base + i) < cap_q.size(); i++) begin
      checks++;
      if (cap_q[base+i] !== EXP_INIT[6+i]) begin
        failures++;
        $display("FAIL ign_cursor_byte%0d: got %h, want %h", i, cap_q[base+i], EXP_INIT[6+i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit ok;
    int base;
    base = cap_q.size();
    @(negedge clk);
    pix_data     = 16'h1234;
    pix_clk      = 1'b1;
    reset_cursor = 1'b1;
    @(negedge clk);
    pix_clk      = 1'b0;
    reset_cursor = 1'b0;
    wait_not_busy(100, ok);
    checks++;
    if (!ok || (cap_q.size() - base) !== 11) begin
      failures++;
      $display("FAIL simul_count: got ok=%b %0d bytes, want 11", ok, cap_q.size() - base);
    end
    for (int i = 0; i < 11 && (base + i) < cap_q.size(); i++) begin
      checks++;
      if (cap_q[base+i] !== EXP_INIT[6+i]) begin
        failures++;
        $display("FAIL simul_byte%0d: got %h, want %h", i, cap_q[base+i], EXP_INIT[6+i]);
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    bit ok;
    int base;
    @(negedge clk);
    pix_data = 16'hBEEF;
    pix_clk  = 1'b1;
    @(negedge clk);
    pix_clk = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({write_edge, dout} !== {1'b0, 8'hEF}) begin
      failures++;
      $display("FAIL mid_setup: got we=%b dout=%h, want 0 ef", write_edge, dout);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({nreset, write_edge, dout, busy, cmd_data} !== {1'b0, 1'b1, 8'h00, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mid_reset: got nreset=%b we=%b dout=%h busy=%b cd=%b, want 0 1 00 1 0",
               nreset, write_edge, dout, busy, cmd_data);
    end
    base = cap_q.size();
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    wait_not_busy(300, ok);
    checks++;
    if (!ok || (cap_q.size() - base) !== 17) begin
      failures++;
      $display("FAIL rerun_count: got ok=%b %0d bytes, want 17", ok, cap_q.size() - base);
    end
    for (int i = 0; i < 17 && (base + i) < cap_q.size(); i++) begin
      checks++;
      if (cap_q[base+i] !== EXP_INIT[i]) begin
        failures++;
        $display("FAIL rerun_byte%0d: got %h, want %h", i, cap_q[base+i], EXP_INIT[i]);
      end
    end
  endtask

  initial begin
    resetn       = 1'b0;
    pix_data     = 16'h0000;
    pix_clk      = 1'b0;
    reset_cursor = 1'b0;
    test_reset();
    test_init_sequence();
    test_pixel();
    test_back_to_back();
    test_ignore_while_busy();
    test_simultaneous();
    test_reset_mid_transfer();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd_pixel_writer.md
Name: lcd_pixel_writer

Overview:
Downstream stage of the TIA. Consumes the TIA's beam-raced pixel stream (pix_data, pix_clk, reset_cursor) and drives an ILI9341 panel over its 8-bit 8080-style parallel bus. Owns panel reset timing, the fixed init command list, cursor/window resets and RGB565 pixel serialisation. Reports busy back to the TIA so pixel issue is throttled.

Parameters:
RESET_LOW_CYC, 16000, cycles nreset is held low after reset (1 ms at 16 MHz)
RESET_WAIT_CYC, 1920000, cycles after nreset rises before the first command (120 ms)
SLEEP_WAIT_CYC, 80000, cycles after the Sleep Out command (5 ms)
WR_HALF, 1, cycles per write_edge phase (low phase, then high phase); must be >=1
MADCTL_VAL, 8'h28, MADCTL data byte (landscape, BGR)

Ports:
clk_i  in  1  system clock, 16 MHz
resetn  in  1  asynchronous active-low reset
pix_data  in  16  RGB565 pixel, sampled when pix_clk=1
pix_clk  in  1  single-cycle pixel strobe
reset_cursor  in  1  single-cycle strobe: home the cursor to the full 320x240 window
busy  out  1  1 = strobes are not accepted
nreset  out  1  panel hardware reset, active low
cmd_data  out  1  0 = command byte, 1 = data byte
write_edge  out  1  panel WRX; the panel latches dout on the rising edge
dout  out  8  panel data bus

Behaviour:
- Reset (async assert, sync release): state=RST_LOW, nreset=0, cmd_data=0, write_edge=1, dout=0, busy=1, counters=0.
- Every output is registered. busy=1 in every state except IDLE.
- Byte transfer (all states that emit): the cycle dout/cmd_data are set, write_edge goes 0 for WR_HALF cycles, then 1 for WR_HALF cycles. dout and cmd_data are stable across the whole 2*WR_HALF window, so 1 byte takes 2*WR_HALF cycles. Bytes are back-to-back with no gap.
- FSM transitions:
  - RST_LOW: after RESET_LOW_CYC -> RST_WAIT, nreset=1.
  - RST_WAIT: after RESET_WAIT_CYC -> INIT_A.
  - INIT_A: sends cmd 11 -> SLEEP_WAIT.
  - SLEEP_WAIT: after SLEEP_WAIT_CYC -> INIT_B.
  - INIT_B: sends cmd 3A, data 55, cmd 36, data MADCTL_VAL, cmd 29 -> CURSOR. The cursor is homed automatically after init.
  - CURSOR: sends cmd 2A, data 00 00 01 3F, cmd 2B, data 00 00 00 EF, cmd 2C (11 bytes) -> IDLE.
  - IDLE, pix_clk=1: latch pix_data -> PIX. PIX sends data pix_data[15:8] then pix_data[7:0] -> IDLE.
  - IDLE, reset_cursor=1: -> CURSOR.
- Latency: a strobe sampled at edge N makes busy=1 from edge N+1. The first write_edge fall is at N+1.
- Pixel occupancy: 4*WR_HALF cycles in PIX plus 1 IDLE cycle. With WR_HALF=1, back-to-back pixels run at 5 cycles each.
- Simultaneous pix_clk and reset_cursor in IDLE: reset_cursor wins and the pixel is dropped.
- Strobes while busy=1 are ignored with no queuing. Upstream must honour busy.
- Reset asserted mid-transfer: outputs return to reset values immediately (async). The full power-up sequence reruns after release.
- Counters are wide enough for the maximum of the wait parameters ($clog2), and saturate to the state exit with no wrap.

Decomposition:
- Package lcd_pkg holds:
  - state enum;
  - command opcodes (SLPOUT=11, COLMOD=3A, MADCTL=36, DISPON=29, CASET=2A, PASET=2B, RAMWR=2C);
  - the CURSOR byte table (11 entries of {cmd_data, byte});
  - LCD_W=320, LCD_H=240.
- One sub-module, lcd_byte_tx. Inputs: start, is_data, byte. Outputs: done, write_edge, dout, cmd_data. It owns the WR_HALF phase timing; the top FSM sequences bytes through it.

Test Plan:
- Reset with RESET_LOW_CYC=4, RESET_WAIT_CYC=8, SLEEP_WAIT_CYC=6 -> nreset=0 for 4 cycles then 1; first write_edge fall 8 cycles later with cmd_data=0, dout=11; busy=1 throughout.
- Full init capture on the rising edges of write_edge -> (c11),(c3A),(d55),(c36),(d28),(c29),(c2A),(d00),(d00),(d01),(d3F),(c2B),(d00),(d00),(d00),(dEF),(c2C); then busy=0.
- IDLE, pix_clk with pix_data=F81F -> busy=1 next cycle; data bytes F8 then 1F; busy=0 exactly 4 cycles later (WR_HALF=1).
- pix_clk pulsed during PIX and during CURSOR -> no extra bytes emitted; total byte count unchanged.
- Same-cycle pix_clk=1 (data 1234) and reset_cursor=1 in IDLE -> the 11-byte cursor sequence is emitted; neither 12 nor 34 appears.
- resetn pulled low during the second pixel byte -> same cycle: nreset=0, write_edge=1, dout=0, busy=1; after release the full init sequence repeats.
